// File: rtl/hazard_scoreboard_pkg.sv
// hzd_pkg: shared widths, forwarding-select encoding, scoreboard entry layout
// and MDU latency defaults for the hazard scoreboard.
package hzd_pkg;

  localparam int HZD_NSTAGE   = 3;
  localparam int HZD_AW       = 5;
  localparam int HZD_TW       = 2;
  localparam int HZD_MULT_CYC = 5;
  localparam int HZD_DIV_CYC  = 10;

  // Forwarding select: FWD_RF reads the register file, k+1 selects entry k.
  localparam int FWD_RF = 0;

  // Default-width view of one in-flight destination write.
  typedef struct packed {
    logic              vld;
    logic [HZD_AW-1:0] dst;
    logic [HZD_TW-1:0] tnew;
  } hzd_entry_t;

  // Map a scoreboard entry index to its forwarding select code.
  function automatic int fwd_entry(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bus: decoded D instruction fields towards the scoreboard and
// stall/forward controls back to the pipeline.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int FW = 2
);
  logic [AW-1:0] rs_d;
  logic [AW-1:0] rt_d;
  logic [TW-1:0] tuse_rs_d;
  logic [TW-1:0] tuse_rt_d;
  logic          wr_d;
  logic [AW-1:0] dst_d;
  logic [TW-1:0] tnew_d;
  logic          md_start_d;
  logic          md_div_d;
  logic          md_use_d;

  logic          stall;
  logic          pc_en;
  logic          if_id_en;
  logic          id_ex_clr;
  logic [FW-1:0] fwd_rs;
  logic [FW-1:0] fwd_rt;
  logic          md_busy;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wr_d, dst_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    input  stall, pc_en, if_id_en, id_ex_clr, fwd_rs, fwd_rt, md_busy
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wr_d, dst_d, tnew_d,
           md_start_d, md_div_d, md_use_d,
    output stall, pc_en, if_id_en, id_ex_clr, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_md_timer.sv
// hzd_md_timer: multiply/divide unit busy tracker. Registers the start that
// left D, then counts the MDU latency down to zero. Only built with HZD_MDU_EN.
`ifdef HZD_MDU_EN
module hzd_md_timer #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  localparam int MAXC    = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC,
  localparam int CW      = $clog2(MAXC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic          start_e_q, start_e_d;
  logic          div_e_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load the latency the cycle after the start reaches E, then count down.
  always_comb begin
    start_e_d = start_i;
    cnt_d     = cnt_q;
    if (start_e_q)
      cnt_d = div_e_q ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  // Control state: reset abandons any count in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_e_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      start_e_q <= start_e_d;
      cnt_q     <= cnt_d;
    end
  end

  // Operation kind travels with the start; only read while start_e_q is set.
  always_ff @(posedge clk) begin
    div_e_q <= div_i;
  end

  assign busy_o = start_e_q || (cnt_q != '0);

endmodule
`endif

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall/forward unit. Keeps an NSTAGE-deep record
// of in-flight GPR writes (E, M, W, ...) with their remaining Tnew, compares it
// against the D operands' Tuse, and optionally tracks the MDU busy window.
// Build option: HZD_MDU_EN enables the MDU counter and MDU stalls.
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter int NSTAGE   = HZD_NSTAGE,
  parameter int AW       = HZD_AW,
  parameter int TW       = HZD_TW,
  parameter int MULT_CYC = HZD_MULT_CYC,
  parameter int DIV_CYC  = HZD_DIV_CYC,
  localparam int FW      = $clog2(NSTAGE + 1)
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave hif
);

  // Tnew counts down as the write moves on, but never wraps below zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [AW-1:0]     dst_q  [NSTAGE];
  logic [AW-1:0]     dst_d  [NSTAGE];
  logic [TW-1:0]     tnew_q [NSTAGE];
  logic [TW-1:0]     tnew_d [NSTAGE];

  logic          stall;
  logic          md_stall;
  logic          md_busy;
  logic          hit_rs, hit_rt;
  logic [TW-1:0] tnew_rs, tnew_rt;
  logic [FW-1:0] sel_rs, sel_rt;
  logic          hz_rs, hz_rt;
  logic [FW-1:0] cand_rs, cand_rt;

  // Shift the scoreboard: D enters entry 0 (a bubble when stalled), older
  // entries age by one stage and the last one falls off.
  always_comb begin
    vld_d[0]  = !stall && hif.wr_d && (hif.dst_d != '0);
    dst_d[0]  = stall ? '0 : hif.dst_d;
    tnew_d[0] = stall ? '0 : hif.tnew_d;
    for (int k = 1; k < NSTAGE; k++) begin
      vld_d[k]  = vld_q[k-1];
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = sat_dec(tnew_q[k-1]);
    end
  end

  // Only the valid bits need reset; stale dst/tnew are masked by vld.
  always_ff @(posedge clk) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // Destination and Tnew fields of the in-flight writes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTAGE; k++) begin
      dst_q[k]  <= dst_d[k];
      tnew_q[k] <= tnew_d[k];
    end
  end

  // Youngest-match lookup per operand; scanning oldest to youngest lets the
  // youngest hit overwrite any older one.
  always_comb begin
    hit_rs  = 1'b0;
    tnew_rs = '0;
    sel_rs  = FW'(FWD_RF);
    hit_rt  = 1'b0;
    tnew_rt = '0;
    sel_rt  = FW'(FWD_RF);
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (vld_q[k] && (dst_q[k] == hif.rs_d) && (hif.rs_d != '0)) begin
        hit_rs  = 1'b1;
        tnew_rs = tnew_q[k];
        sel_rs  = FW'(fwd_entry(k));
      end
      if (vld_q[k] && (dst_q[k] == hif.rt_d) && (hif.rt_d != '0)) begin
        hit_rt  = 1'b1;
        tnew_rt = tnew_q[k];
        sel_rt  = FW'(fwd_entry(k));
      end
    end
    hz_rs   = hit_rs && (tnew_rs > hif.tuse_rs_d);
    hz_rt   = hit_rt && (tnew_rt > hif.tuse_rt_d);
    cand_rs = (hit_rs && (tnew_rs == '0)) ? sel_rs : FW'(FWD_RF);
    cand_rt = (hit_rt && (tnew_rt == '0)) ? sel_rt : FW'(FWD_RF);
  end

`ifdef HZD_MDU_EN
  // Any HI/LO user or new MDU start waits while the unit is busy.
  assign md_stall = (hif.md_use_d || hif.md_start_d) && md_busy;

  hzd_md_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start_i (hif.md_start_d && !stall),
    .div_i   (hif.md_div_d),
    .busy_o  (md_busy)
  );
`else
  localparam int MD_CYC_UNUSED = MULT_CYC + DIV_CYC;
  logic md_unused;
  assign md_unused = ^{hif.md_start_d, hif.md_div_d, hif.md_use_d};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign stall         = hz_rs || hz_rt || md_stall;
  assign hif.stall     = stall;
  assign hif.pc_en     = !stall;
  assign hif.if_id_en  = !stall;
  assign hif.id_ex_clr = stall;
  assign hif.fwd_rs    = stall ? FW'(FWD_RF) : cand_rs;
  assign hif.fwd_rt    = stall ? FW'(FWD_RF) : cand_rt;
  assign hif.md_busy   = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; MDU steps are built with HZD_MDU_EN.
module tb_hazard_scoreboard;
  import hzd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(5), .TW(2), .FW(2)) hif ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic wr, input logic [4:0] dst, input logic [1:0] tnew);
    hif.rs_d       = rs;
    hif.tuse_rs_d  = tur;
    hif.rt_d       = rt;
    hif.tuse_rt_d  = tut;
    hif.wr_d       = wr;
    hif.dst_d      = dst;
    hif.tnew_d     = tnew;
    hif.md_start_d = 1'b0;
    hif.md_div_d   = 1'b0;
    hif.md_use_d   = 1'b0;
    #1;
  endtask

  task automatic md(input logic start, input logic dv, input logic use_hl);
    hif.md_start_d = start;
    hif.md_div_d   = dv;
    hif.md_use_d   = use_hl;
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_stall", hif.stall, 0);
    chk("rst_pc_en", hif.pc_en, 1);
    chk("rst_if_id_en", hif.if_id_en, 1);
    chk("rst_id_ex_clr", hif.id_ex_clr, 0);
    chk("rst_fwd_rs", hif.fwd_rs, 0);
    chk("rst_fwd_rt", hif.fwd_rt, 0);
    chk("rst_md_busy", hif.md_busy, 0);

    // lw r2 (tnew 2) then add reading r2 (tuse 1)
    drive(0, 0, 0, 0, 1, 2, 2);
    chk("lw_no_stall", hif.stall, 0);
    tick();
    drive(2, 1, 0, 0, 1, 5, 1);
    chk("lw_use_stall", hif.stall, 1);
    chk("lw_use_clr", hif.id_ex_clr, 1);
    chk("lw_use_pc_en", hif.pc_en, 0);
    chk("lw_use_fwd_rs", hif.fwd_rs, 0);
    tick();
    chk("lw_release", hif.stall, 0);
    chk("lw_m_tnew1_fwd", hif.fwd_rs, 0);
    tick();
    drive(2, 0, 0, 0, 0, 0, 0);
    chk("lw_w_fwd_rs", hif.fwd_rs, 3);
    chk("lw_w_stall", hif.stall, 0);

    // addu r3 (tnew 1) then sw reading r3 as rt (tuse 2)
    flush();
    drive(0, 0, 0, 0, 1, 3, 1);
    tick();
    drive(0, 0, 3, 2, 0, 0, 0);
    chk("sw_no_stall", hif.stall, 0);
    chk("sw_fwd_rt_e", hif.fwd_rt, 0);
    tick();
    chk("sw_fwd_rt_m", hif.fwd_rt, 2);
    drive(0, 0, 0, 0, 1, 6, 0);
    tick();
    drive(6, 0, 0, 0, 0, 0, 0);
    chk("e_fwd_rs", hif.fwd_rs, 1);
    chk("e_fwd_stall", hif.stall, 0);

    // r4 written in E (tnew 3) and M (tnew 0): only E counts
    flush();
    drive(0, 0, 0, 0, 1, 4, 1);
    tick();
    drive(0, 0, 0, 0, 1, 4, 3);
    tick();
    drive(4, 2, 4, 3, 0, 0, 0);
    chk("young_rs_stall", hif.stall, 1);
    chk("young_fwd_rs", hif.fwd_rs, 0);
    drive(0, 0, 4, 3, 0, 0, 0);
    chk("young_rt_stall", hif.stall, 0);
    chk("young_fwd_rt", hif.fwd_rt, 0);
    drive(4, 0, 4, 0, 0, 0, 0);
    chk("both_stall", hif.stall, 1);
    chk("both_clr", hif.id_ex_clr, 1);

    // write to r0 is never a hazard
    flush();
    drive(0, 0, 0, 0, 1, 0, 3);
    tick();
    drive(0, 3, 0, 3, 0, 0, 0);
    chk("r0_stall", hif.stall, 0);
    chk("r0_fwd_rs", hif.fwd_rs, 0);
    chk("r0_fwd_rt", hif.fwd_rt, 0);

    // tnew 0 stays 0 all the way to W
    flush();
    drive(0, 0, 0, 0, 1, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(7, 0, 0, 0, 0, 0, 0);
    chk("sat_stall", hif.stall, 0);
    chk("sat_fwd_rs", hif.fwd_rs, 3);

    // reset with a live hazard clears the scoreboard
    flush();
    drive(0, 0, 0, 0, 1, 8, 3);
    tick();
    drive(8, 0, 0, 0, 0, 0, 0);
    chk("prerst_stall", hif.stall, 1);
    reset = 1'b0;
    tick();
    chk("rst_hz_stall", hif.stall, 0);
    chk("rst_hz_fwd_rs", hif.fwd_rs, 0);
    chk("rst_hz_pc_en", hif.pc_en, 1);
    reset = 1'b1;

`ifdef HZD_MDU_EN
    begin
      int cyc;
      // mult then mflo
      flush();
      md(1, 0, 0);
      chk("mult_issue_stall", hif.stall, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      md(0, 0, 1);
      chk("mult_busy", hif.md_busy, 1);
      cyc = 0;
      while (hif.stall && cyc < 40) begin
        cyc++;
        tick();
      end
      chk("mult_stall_cycles", cyc, 6);
      chk("mult_idle", hif.md_busy, 0);
      // div then mflo
      md(1, 1, 0);
      tick();
      md(0, 0, 1);
      cyc = 0;
      while (hif.stall && cyc < 40) begin
        cyc++;
        tick();
      end
      chk("div_stall_cycles", cyc, 11);
      // second start waits, then reset abandons the count
      md(1, 0, 0);
      tick();
      md(1, 0, 0);
      chk("md_restart_stall", hif.stall, 1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("md_rst_busy", hif.md_busy, 0);
      chk("md_rst_stall", hif.stall, 0);
      chk("md_rst_fwd_rs", hif.fwd_rs, 0);
      chk("md_rst_fwd_rt", hif.fwd_rt, 0);
      reset = 1'b1;
      md(0, 0, 0);
    end
`else
    flush();
    md(1, 0, 0);
    tick();
    md(0, 0, 1);
    chk("nomdu_busy", hif.md_busy, 0);
    chk("nomdu_stall", hif.stall, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
